// File: rtl/lc3b_types.sv
// Shared LC-3b types for the fetch stage: word type, reset PC, fetch FSM states, IF/ID record.
// Included ahead of every file that does `import lc3b_types::*`.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   localparam lc3b_word LC3B_RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      IF_RUN     = 2'd0,
      IF_HOLD    = 2'd1,
      IF_DISCARD = 2'd2
   } lc3b_ifetch_state;

   typedef struct packed {
      logic     valid;
      lc3b_word ir;
      lc3b_word pc;
   } lc3b_if_id;

   // Instructions are 2 bytes; wraps modulo 2^16.
   function automatic lc3b_word lc3b_pc_inc(input lc3b_word pc);
      return pc + 16'd2;
   endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// I-cache fetch port: the fetch stage is master (request/address), the cache is slave (data/resp).
// resp is re-asserted every cycle while read stays high on the same address.
interface ifetch_stage_if;
   import lc3b_types::*;

   logic     icache_read;
   lc3b_word icache_address;
   lc3b_word icache_rdata;
   logic     icache_resp;

   modport master (
      output icache_read,
      output icache_address,
      input  icache_rdata,
      input  icache_resp
   );

   modport slave (
      input  icache_read,
      input  icache_address,
      output icache_rdata,
      output icache_resp
   );

endinterface

// File: rtl/ifetch_pc_reg.sv
// Fetch PC register with next-pc mux: redirect (bit 0 forced low) > advance by 2 > hold.
// Latency: new pc visible one edge after redirect/advance; no backpressure of its own.
// Backpressure: holds whenever the caller does not advance.
module ifetch_pc_reg
   import lc3b_types::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     redirect_valid,
   input  lc3b_word redirect_pc,
   input  logic     advance,
   output lc3b_word pc,
   output lc3b_word pc_inc
);

   lc3b_word pc_nxt;

   assign pc_inc = lc3b_pc_inc(pc);

   always_comb begin
      pc_nxt = pc;
      if (redirect_valid) begin
         pc_nxt = redirect_pc & 16'hFFFE;
      end else if (advance) begin
         pc_nxt = pc_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= LC3B_RESET_PC;
      end else begin
         pc <= pc_nxt;
      end
   end

endmodule

// File: rtl/ifetch_stage.sv
// LC-3b instruction fetch: I-cache request FSM plus IF/ID register; IFETCH_SKID_EN adds a 1-entry skid.
// Latency: cache resp -> IF/ID valid on the next edge, one instruction per cycle on hits.
// Backpressure: stall holds IF/ID; request held on its address (no skid) or one word parked in skid with fetch paused.
module ifetch_stage
   import lc3b_types::*;
(
   input  logic           clk,
   input  logic           rst_n,
   ifetch_stage_if.master ic,
   input  logic           stall,
   input  logic           redirect_valid,
   input  lc3b_word       redirect_pc,
   output logic           if_id_valid,
   output lc3b_word       if_id_ir,
   output lc3b_word       if_id_pc
);

   lc3b_ifetch_state state;
   lc3b_ifetch_state state_nxt;
   lc3b_word         pc;
   lc3b_word         pc_inc;
   lc3b_word         discard_addr;
   lc3b_if_id        if_id_q;
   logic             slot_free;
   logic             accept;
   logic             advance;
   logic             enter_discard;
`ifdef IFETCH_SKID_EN
   lc3b_if_id        skid_q;
   logic             capture;
   logic             skid_move;
`endif

   assign slot_free     = !if_id_q.valid || !stall;
   // A redirect with the fetch still outstanding must wait out that response on the old address.
   assign enter_discard = (state == IF_RUN) && redirect_valid && !ic.icache_resp;

`ifdef IFETCH_SKID_EN
   assign advance = accept || capture;
`else
   assign advance = accept;
`endif

   ifetch_pc_reg u_pc_reg (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .advance        (advance),
      .pc             (pc),
      .pc_inc         (pc_inc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IF_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IF_RUN: begin
            if (redirect_valid) begin
               state_nxt = ic.icache_resp ? IF_RUN : IF_DISCARD;
            end
`ifdef IFETCH_SKID_EN
            else if (capture) begin
               state_nxt = IF_HOLD;
            end
`endif
         end
         IF_DISCARD: begin
            if (!redirect_valid && ic.icache_resp) begin
               state_nxt = IF_RUN;
            end
         end
`ifdef IFETCH_SKID_EN
         IF_HOLD: begin
            if (redirect_valid || slot_free) begin
               state_nxt = IF_RUN;
            end
         end
`endif
         default: state_nxt = IF_RUN;
      endcase
   end

   // icache_read is gated by rst_n so it drops the instant reset asserts.
   always_comb begin
      ic.icache_read    = 1'b0;
      ic.icache_address = pc;
      accept            = 1'b0;
`ifdef IFETCH_SKID_EN
      capture           = 1'b0;
      skid_move         = 1'b0;
`endif
      case (state)
         IF_RUN: begin
            ic.icache_read = rst_n;
            accept         = ic.icache_resp && slot_free;
`ifdef IFETCH_SKID_EN
            capture        = ic.icache_resp && !slot_free;
`endif
         end
         IF_DISCARD: begin
            ic.icache_read    = rst_n;
            ic.icache_address = discard_addr;
         end
`ifdef IFETCH_SKID_EN
         IF_HOLD: begin
            skid_move = slot_free;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         discard_addr <= LC3B_RESET_PC;
      end else if (enter_discard) begin
         discard_addr <= pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_q <= '0;
      end else if (redirect_valid) begin
         if_id_q.valid <= 1'b0;
      end else if (accept) begin
         if_id_q <= '{valid: 1'b1, ir: ic.icache_rdata, pc: pc_inc};
      end
`ifdef IFETCH_SKID_EN
      else if (skid_move) begin
         if_id_q <= skid_q;
      end
`endif
      else if (slot_free) begin
         if_id_q.valid <= 1'b0;
      end
   end

`ifdef IFETCH_SKID_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q <= '0;
      end else if (redirect_valid) begin
         skid_q.valid <= 1'b0;
      end else if (capture) begin
         skid_q <= '{valid: 1'b1, ir: ic.icache_rdata, pc: pc_inc};
      end else if (skid_move) begin
         skid_q.valid <= 1'b0;
      end
   end
`endif

   assign if_id_valid = if_id_q.valid;
   assign if_id_ir    = if_id_q.ir;
   assign if_id_pc    = if_id_q.pc;

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: cache model with programmable miss latency, directed scenarios, then random
// stall/redirect traffic; consumed instructions are scoreboarded against the sequential program from the last target.
module tb_ifetch_stage;
   import lc3b_types::*;

   typedef struct {
      lc3b_word ir;
      lc3b_word pc;
   } exp_t;

   logic     clk;
   logic     rst_n;
   logic     stall;
   logic     redirect_valid;
   lc3b_word redirect_pc;
   logic     if_id_valid;
   lc3b_word if_id_ir;
   lc3b_word if_id_pc;

   int   n_tests = 0;
   int   n_fail = 0;
   int   n_consumed = 0;
   int   miss_lat = 0;
   exp_t exp_q[$];

   ifetch_stage_if ic ();

   ifetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ic             (ic),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id_valid    (if_id_valid),
      .if_id_ir       (if_id_ir),
      .if_id_pc       (if_id_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Program image: distinct word per even address, with one planted instruction at 0x0020.
   function automatic lc3b_word mem(input lc3b_word a);
      logic [31:0] m;
      if (a == 16'h0020) return 16'h1261;
      m = {16'd0, a} * 32'd40503;
      return m[15:0] ^ 16'h3C5A;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // Expected program order from a fetch target: each consumed entry is (mem(a), a+2).
   task automatic refill(input lc3b_word start);
      lc3b_word a;
      lc3b_word p;
      a = start;
      exp_q.delete();
      for (int i = 0; i < 512; i++) begin
         p = a + 16'd2;
         exp_q.push_back('{ir: mem(a), pc: p});
         a = p;
      end
   endtask

   // Cache: a new request takes miss_lat cycles (random 0..3 when negative); resp repeats while held.
   initial begin
      logic     c_prev;
      lc3b_word c_addr;
      int       c_cnt;
      c_prev = 1'b0;
      c_addr = '0;
      c_cnt  = 0;
      ic.icache_resp  = 1'b0;
      ic.icache_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (ic.icache_read) begin
            if (!(c_prev && ic.icache_address == c_addr)) begin
               c_addr = ic.icache_address;
               c_cnt  = (miss_lat < 0) ? int'($urandom_range(0, 3)) : miss_lat;
            end else if (c_cnt > 0) begin
               c_cnt--;
            end
            ic.icache_resp  = (c_cnt == 0);
            ic.icache_rdata = ic.icache_resp ? mem(c_addr) : 16'($urandom);
            c_prev = 1'b1;
         end else begin
            ic.icache_resp  = 1'b0;
            ic.icache_rdata = 16'($urandom);
            c_prev = 1'b0;
         end
      end
   end

   // Monitor: decode consumes IF/ID when valid && !stall; also checks request-hold protocol.
   logic     p_ok = 1'b0;
   logic     p_read;
   logic     p_resp;
   logic     p_valid;
   logic     p_stall;
   logic     p_redir;
   lc3b_word p_addr;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (if_id_valid && !stall) begin
            n_consumed++;
            if (exp_q.size() == 0) begin
               chk("sb_empty", if_id_pc, 16'hFFFF);
            end else begin
               e = exp_q.pop_front();
               chk("sb_ir", if_id_ir, e.ir);
               chk("sb_pc", if_id_pc, e.pc);
            end
         end
         if (p_ok && p_read && !p_resp) begin
            chk("held_read", {15'd0, ic.icache_read}, 16'd1);
            chk("held_addr", ic.icache_address, p_addr);
         end
`ifndef IFETCH_SKID_EN
         if (p_ok && p_read && p_resp && p_valid && p_stall && !p_redir) begin
            chk("stalled_read", {15'd0, ic.icache_read}, 16'd1);
            chk("stalled_addr", ic.icache_address, p_addr);
         end
`endif
         if (ic.icache_read) chk("addr_even", {15'd0, ic.icache_address[0]}, 16'd0);
      end
      p_ok    = rst_n;
      p_read  = ic.icache_read;
      p_resp  = ic.icache_resp;
      p_valid = if_id_valid;
      p_stall = stall;
      p_redir = redirect_valid;
      p_addr  = ic.icache_address;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      logic found;
      rst_n          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      miss_lat       = 0;
      refill(LC3B_RESET_PC);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_read", {15'd0, ic.icache_read}, 16'd0);
      chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
      chk("rst_ir", if_id_ir, 16'h0000);
      chk("rst_pc", if_id_pc, 16'h0000);

      // Streaming hits after reset release.
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("c0_read", {15'd0, ic.icache_read}, 16'd1);
      chk("c0_addr", ic.icache_address, 16'h0000);
      chk("c0_valid", {15'd0, if_id_valid}, 16'd0);
      @(negedge clk);
      chk("c1_addr", ic.icache_address, 16'h0002);
      chk("c1_ifid_pc", if_id_pc, 16'h0002);
      @(negedge clk);
      chk("c2_addr", ic.icache_address, 16'h0004);
      chk("c2_ifid_pc", if_id_pc, 16'h0004);
      @(negedge clk);
      chk("c3_ifid_pc", if_id_pc, 16'h0006);

      // Stall three cycles while IF/ID holds 0x1261.
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk); #1;
         if (if_id_valid && if_id_ir == 16'h1261) found = 1'b1;
      end
      chk("stall_setup", {15'd0, found}, 16'd1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_ir", if_id_ir, 16'h1261);
         chk("stall_pc", if_id_pc, 16'h0022);
         chk("stall_valid", {15'd0, if_id_valid}, 16'd1);
         if (k > 0) begin
`ifdef IFETCH_SKID_EN
            chk("skid_read_low", {15'd0, ic.icache_read}, 16'd0);
`else
            chk("stall_read_high", {15'd0, ic.icache_read}, 16'd1);
            chk("stall_addr", ic.icache_address, 16'h0022);
`endif
         end
      end
      @(posedge clk); #1 stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("unstall_ir", if_id_ir, mem(16'h0022));
      chk("unstall_pc", if_id_pc, 16'h0024);
      @(negedge clk);
      chk("unstall_next_pc", if_id_pc, 16'h0026);

      // Redirect to an odd target together with a hit: data dropped, fetch at 0x3000.
      @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 16'h3001;
      @(negedge clk); #1 refill(16'h3000);
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir_addr", ic.icache_address, 16'h3000);
      chk("redir_read", {15'd0, ic.icache_read}, 16'd1);
      chk("redir_valid", {15'd0, if_id_valid}, 16'd0);
      @(negedge clk);
      chk("redir_ifid_pc", if_id_pc, 16'h3002);
      chk("redir_ifid_ir", if_id_ir, mem(16'h3000));

      // Redirect to 0x0100 while the fetch of 0x3004 misses; resp arrives four cycles later.
      @(posedge clk); #1 miss_lat = 5;
      @(negedge clk);
      chk("miss_addr", ic.icache_address, 16'h3004);
      @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 16'h0100; miss_lat = 0;
      @(negedge clk); #1 refill(16'h0100);
      @(posedge clk); #1 redirect_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("discard_addr", ic.icache_address, 16'h3004);
         chk("discard_read", {15'd0, ic.icache_read}, 16'd1);
         chk("discard_valid", {15'd0, if_id_valid}, 16'd0);
      end
      @(negedge clk);
      chk("post_discard_addr", ic.icache_address, 16'h0100);
      @(negedge clk);
      chk("post_discard_pc", if_id_pc, 16'h0102);
      chk("post_discard_ir", if_id_ir, mem(16'h0100));

      // PC wrap at 0xFFFE.
      @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
      @(negedge clk); #1 refill(16'hFFFE);
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      chk("wrap_addr0", ic.icache_address, 16'hFFFE);
      @(negedge clk);
      chk("wrap_addr1", ic.icache_address, 16'h0000);
      chk("wrap_ifid_pc", if_id_pc, 16'h0000);
      chk("wrap_ifid_ir", if_id_ir, mem(16'hFFFE));

      // Reset pulse in the middle of a miss.
      @(posedge clk); #1 miss_lat = 6;
      @(posedge clk); #1;
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("arst_read", {15'd0, ic.icache_read}, 16'd0);
      chk("arst_valid", {15'd0, if_id_valid}, 16'd0);
      chk("arst_ir", if_id_ir, 16'h0000);
      chk("arst_pc", if_id_pc, 16'h0000);
      refill(LC3B_RESET_PC);
      miss_lat = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("restart_addr", ic.icache_address, 16'h0000);
      chk("restart_read", {15'd0, ic.icache_read}, 16'd1);
      @(negedge clk);
      chk("restart_ifid_pc", if_id_pc, 16'h0002);
      chk("restart_ifid_ir", if_id_ir, mem(16'h0000));

      // Random traffic: stalls, redirects (odd targets included) and variable miss latency.
      miss_lat = -1;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         stall          = ($urandom_range(0, 99) < 30);
         redirect_valid = ($urandom_range(0, 99) < 5);
         redirect_pc    = 16'($urandom);
         @(negedge clk); #1;
         if (redirect_valid) refill(redirect_pc & 16'hFFFE);
      end
      @(posedge clk); #1 redirect_valid = 1'b0; stall = 1'b0;
      repeat (8) @(negedge clk);
      chk("consumed_enough", {15'd0, (n_consumed >= 400)}, 16'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 icache_read  out  1  instruction fetch request to the I-cache.
REQ-005 icache_address  out  16  byte address of the fetch; bit 0 always 0.
REQ-006 icache_rdata  in  16  instruction word; valid when icache_resp=1.
REQ-007 icache_resp  in  1  fetch complete; cache re-asserts it every cycle while icache_read stays high on the same address.
REQ-008 stall  in  1  decode cannot accept; IF/ID holds.
REQ-009 redirect_valid  in  1  taken branch/JMP/JSR/TRAP from the memory stage.
REQ-010 redirect_pc  in  16  new fetch target.
REQ-011 if_id_valid  out  1  IF/ID holds a live instruction.
REQ-012 if_id_ir  out  16  fetched instruction.
REQ-013 if_id_pc  out  16  fetch address + 2, the incremented PC used by BR/JSR/LEA.

Function
REQ-014 States: RUN (request issued), HOLD (word captured in the skid register, no request), DISCARD (wait out a fetch killed by a redirect).
REQ-015 slot_free = !if_id_valid || !stall; an accept is icache_resp && slot_free in RUN.
REQ-016 In RUN, icache_read=1 and icache_address=pc; the address is held stable until an accept or redirect.
REQ-017 On an accept without redirect, next edge: if_id_ir<=icache_rdata, if_id_pc<=pc+2, if_id_valid<=1, pc<=pc+2; icache_read stays 1 for the new pc (one instruction per cycle when the cache hits).
REQ-018 When stall=1 and if_id_valid=1, IF/ID registers SHALL hold their values.
REQ-019 When slot_free=1 and no accept occurs, if_id_valid<=0 next edge.
REQ-020 redirect_valid has priority over all other events: next edge pc<={redirect_pc[15:1],1'b0} and if_id_valid<=0, regardless of stall.
REQ-021 Redirect in the same cycle as icache_resp: drop the data and go to RUN at the new pc.
REQ-022 Redirect while a request is outstanding with no icache_resp: go to DISCARD; icache_read stays 1 on the old address until icache_resp, then return to RUN with the new pc; nothing is written to IF/ID.
REQ-023 A redirect arriving in DISCARD SHALL update pc again and remain in DISCARD.
REQ-024 PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000.

Reset
REQ-025 While rst_n=0: pc=LC3B_RESET_PC (16'h0000), state=RUN, if_id_valid=0, if_id_ir=0, if_id_pc=0, skid register empty.
REQ-026 icache_read SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after release.
REQ-027 Reset asserted mid-fetch SHALL abandon the request; no IF/ID write may follow.

Configuration
REQ-028 Macro IFETCH_SKID_EN.
- Defined: an icache_resp with slot_free=0 is captured into a 1-entry skid register (data, pc+2). Next edge pc<=pc+2 and the block goes to HOLD with icache_read=0. When slot_free=1, the skid entry moves to IF/ID and the block returns to RUN.
- A redirect in HOLD empties the skid register and goes to RUN.
REQ-029 Undefined: there is no skid register and no HOLD state. An icache_resp with slot_free=0 is ignored, and icache_read stays 1 on the same address until it is accepted.

Structure
REQ-030 lc3b_types SHALL gain the LC3B_RESET_PC constant, the lc3b_ifetch_state enum and a packed lc3b_if_id struct {valid, ir, pc}; ports use lc3b_word.
REQ-031 One sub-module, ifetch_pc_reg, holds pc and its next-pc mux (pc+2, redirect, hold); the FSM and IF/ID stay in ifetch_stage.

Verification
REQ-032 Release reset with the cache hitting every cycle: addresses 0000, 0002, 0004 are issued; if_id_pc=0002, 0004, 0006 in successive cycles.
REQ-033 stall=1 for 3 cycles with IF/ID holding ir=16'h1261: IF/ID is unchanged. With the skid enabled, icache_read drops after one resp. Without it, icache_read stays high on the same address. After release, the next IR appears exactly once.
REQ-034 Redirect to 16'h3001 with resp in the same cycle: data is dropped, the next address is 3000 and if_id_valid=0 for that cycle.
REQ-035 Redirect to 16'h0100 while a miss is pending (resp 4 cycles later): the old address is held until resp, then the address is 0100; no stale IR reaches IF/ID.
REQ-036 pc=16'hFFFE with a hit: the next address is 0000 and if_id_pc=0000.
REQ-037 rst_n pulsed low mid-miss: all outputs return to their reset values asynchronously, and the fetch restarts at 0000.
